// File: rtl/jedro_1_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_lsu_if
// Purpose  : Bundles the jedro_1 LSU signals: the decoder request side, the
//            regfile writeback side and the byte-enabled data RAM port.
//            The slave modport is the LSU; the master modport is its
//            surroundings (decoder, regfile, RAM).
// Revision : 1.0 - initial release
// ============================================================================
interface jedro_1_lsu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // Decoder request side
  logic                      lsu_new_ctrl_i;
  logic [3:0]                lsu_ctrl_i;
  logic [ADDR_WIDTH-1:0]     lsu_addr_i;
  logic [DATA_WIDTH-1:0]     lsu_wdata_i;
  logic [REG_ADDR_WIDTH-1:0] lsu_regdest_i;
  logic                      lsu_busy_o;

  // Regfile writeback and error side
  logic                      lsu_wb_o;
  logic [REG_ADDR_WIDTH-1:0] lsu_wb_addr_o;
  logic [DATA_WIDTH-1:0]     lsu_wb_data_o;
  logic                      lsu_err_o;

  // Data RAM side
  logic                      ram_en_o;
  logic [DATA_WIDTH/8-1:0]   ram_we_o;
  logic [ADDR_WIDTH-1:0]     ram_addr_o;
  logic [DATA_WIDTH-1:0]     ram_wdata_o;
  logic [DATA_WIDTH-1:0]     ram_rdata_i;

  modport slave (
    input  lsu_new_ctrl_i, lsu_ctrl_i, lsu_addr_i, lsu_wdata_i, lsu_regdest_i,
    input  ram_rdata_i,
    output lsu_busy_o, lsu_wb_o, lsu_wb_addr_o, lsu_wb_data_o, lsu_err_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output lsu_new_ctrl_i, lsu_ctrl_i, lsu_addr_i, lsu_wdata_i, lsu_regdest_i,
    output ram_rdata_i,
    input  lsu_busy_o, lsu_wb_o, lsu_wb_addr_o, lsu_wb_data_o, lsu_err_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/jedro_1_lsu.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_lsu
// Purpose  : Load/store unit of the jedro_1 core. Accepts one memory op at a
//            time from the decoder, drives the byte-enabled 32b data RAM and
//            returns sign/zero-extended load data to the regfile.
//            IDLE -> REQ (RAM access) -> RESP (loads only) -> IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic          clk_i,
  input logic          rst_i,
  jedro_1_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WE_WIDTH = DATA_WIDTH / 8;

  // funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t state_q, state_d;

  // Latched op: only what the response phase still needs
  logic                      is_store_q, is_store_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                off_q, off_d;
  logic [REG_ADDR_WIDTH-1:0] regdest_q, regdest_d;

  // Registered outputs
  logic                      ram_en_q, ram_en_d;
  logic [WE_WIDTH-1:0]       ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
  logic                      wb_q, wb_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      err_q, err_d;

  // Request decode
  logic                      req_store;
  logic [2:0]                req_f3;
  logic                      req_illegal;
  logic                      req_misaligned;
  logic [WE_WIDTH-1:0]       st_we;
  logic [DATA_WIDTH-1:0]     st_wdata;

  // Load data extraction
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [DATA_WIDTH-1:0]     ld_ext;

  assign req_store = bus.lsu_ctrl_i[3];
  assign req_f3    = bus.lsu_ctrl_i[2:0];

  // Classify the incoming request: illegal funct3 and natural alignment by size
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_store) begin
      req_illegal = !((req_f3 == F3_B) || (req_f3 == F3_H) || (req_f3 == F3_W));
    end else begin
      req_illegal = (req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111);
    end
    // funct3[1:0] encodes the access size for both signed and unsigned forms
    case (req_f3[1:0])
      2'b01:   req_misaligned = bus.lsu_addr_i[0];
      2'b10:   req_misaligned = |bus.lsu_addr_i[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Store lane steering: byte enables by offset, data replicated into every lane
  always_comb begin
    st_we    = '0;
    st_wdata = bus.lsu_wdata_i;
    case (req_f3[1:0])
      2'b00: begin
        st_we    = WE_WIDTH'(4'b0001 << bus.lsu_addr_i[1:0]);
        st_wdata = {4{bus.lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        st_we    = bus.lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.lsu_wdata_i[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = bus.lsu_wdata_i;
      end
    endcase
    // A load reads with all enables clear
    if (!req_store) begin
      st_we = '0;
    end
  end

  // Pick the addressed lane out of the RAM word and extend it per funct3
  always_comb begin
    ld_byte = bus.ram_rdata_i[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus.ram_rdata_i[31:16] : bus.ram_rdata_i[15:0];
    case (funct3_q)
      F3_B:    ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_H:    ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_ext = bus.ram_rdata_i;
    endcase
  end

  // Next-state and registered-output logic; pulses default low every cycle
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    regdest_d   = regdest_q;
    ram_en_d    = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wb_d        = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.lsu_new_ctrl_i) begin
          is_store_d = req_store;
          funct3_d   = req_f3;
          off_d      = bus.lsu_addr_i[1:0];
          regdest_d  = bus.lsu_regdest_i;
          if (req_illegal || req_misaligned) begin
            // Rejected op never touches the RAM
            err_d = 1'b1;
          end else begin
            // RAM controls are registered here so they appear while in REQ
            state_d     = REQ;
            ram_en_d    = 1'b1;
            ram_we_d    = st_we;
            ram_addr_d  = {bus.lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
            ram_wdata_d = st_wdata;
          end
        end
      end
      REQ: begin
        state_d = is_store_q ? IDLE : RESP;
      end
      RESP: begin
        // Read data is valid now; writeback pulses in the following cycle
        wb_d      = 1'b1;
        wb_addr_d = regdest_q;
        wb_data_d = ld_ext;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any op in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      regdest_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wb_q        <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      regdest_q   <= regdest_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wb_q        <= wb_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.lsu_busy_o    = (state_q != IDLE);
  assign bus.lsu_wb_o      = wb_q;
  assign bus.lsu_wb_addr_o = wb_addr_q;
  assign bus.lsu_wb_data_o = wb_data_q;
  assign bus.lsu_err_o     = err_q;
  assign bus.ram_en_o      = ram_en_q;
  assign bus.ram_we_o      = ram_we_q;
  assign bus.ram_addr_o    = ram_addr_q;
  assign bus.ram_wdata_o   = ram_wdata_q;

endmodule
`default_nettype wire
